sha256_padder: RTL and testbench
================================

Name: sha256_padder

Overview:
- Producer side of the 32-bit word FIFO that feeds the SHA-256 engine.
- Takes a raw message as a stream of big-endian 32-bit words plus its byte length, and applies SHA-256 preprocessing: append 0x80, zero-fill, and add a 64-bit big-endian bit length.
- Writes the complete padded message into the FIFO as whole 512-bit blocks (16 words each).
- Sits between the AXI/register-side message buffer and the engine's input FIFO.

Parameters:
- LEN_W, 32, width of the byte-length input; legal range 8..61.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- start_i  in  1  one-cycle pulse; accepted only when ready_o=1
- msg_len_i  in  LEN_W  message length in bytes; sampled on accepted start_i
- ready_o  out  1  idle, can accept start_i
- in_vld_i  in  1  input word valid
- in_rdy_o  out  1  input word accepted this cycle when in_vld_i & in_rdy_o
- in_dat_i  in  32  message word, first byte in [31:24]
- fifo_full  in  1  engine FIFO full
- fifo_wr_en  out  1  write strobe, exactly one word per asserted cycle
- fifo_wr_dat  out  32  padded word
- blocks_o  out  16  count of 512-bit blocks written for the current job (saturating)
- done_o  out  1  one-cycle pulse after the last length word is written
- nonce_ofs_i  in  4  (feature only) word index within the final block
- nonce_i  in  32  (feature only) nonce value

Behaviour:
- Reset values: ready_o=1, in_rdy_o=0, fifo_wr_en=0, fifo_wr_dat=0, blocks_o=0, done_o=0. All counters are 0 and the FSM is in IDLE.
- Reset asserted mid-job aborts the job immediately; no further FIFO writes occur. FIFO contents are the system's responsibility.
- Registered outputs. The FIFO write happens in the cycle after the decision. A word is produced only in a cycle where fifo_full=0, so the block never writes while full.
- Counters: wcnt[3:0] is the word index within the current block and wraps 15->0. Each wrap increments blocks_o. The byte counter remaining tracks bytes still to consume.
- FSM:
  - IDLE: ready_o=1. On start_i, latch msg_len_i and clear blocks_o. Go to DATA if len>0, else go to PAD80.
  - DATA: in_rdy_o = !fifo_full.
    - Each accepted word is written and remaining decrements by min(4, remaining).
    - On the final word with r = len mod 4 != 0: keep the top r bytes, put 0x80 in byte r, zero the rest. Then go to ZERO.
    - If r == 0, the final word is written unchanged and the FSM goes to PAD80.
  - PAD80: write 0x80000000, then go to ZERO.
  - ZERO: write 0x00000000 while wcnt != 14.
    - If the 0x80-bearing word lands at wcnt 14 or 15, zero-fill through 15 and a full next block until wcnt == 14.
  - LENHI: write {zero-extended bit length}[63:32].
  - LENLO: write the bit length [31:0], where bit length = len<<3 within 64 bits. Pulse done_o and go to IDLE.
- Total words written = 16 * (floor((len+8)/64) + 1).
- Block count examples: len=55 gives 1 block, len=56 gives 2, len=64 gives 2.
- in_rdy_o=0 in every state except DATA. Input words presented outside DATA are ignored.
- start_i while busy is ignored.
- in_vld_i=0 in DATA stalls the job with no output. There is no timeout.

Optional Feature:
- Macro: SHA256_PADDER_NONCE_EN.
- Defined: during the final block, the word at wcnt == nonce_ofs_i is replaced by nonce_i (data, pad, or zero word alike). This allows the nonce to be swept without rewriting the message. nonce_ofs_i 14/15 is illegal, and the length words win over the nonce.
- Undefined: the nonce ports are absent and data passes through unmodified.

Decomposition:
- Package sha256_pkg:
  - state enum (IDLE, DATA, PAD80, ZERO, LENHI, LENLO)
  - SHA256_BLOCK_WORDS=16 and SHA256_LEN_WORD_IDX=14
  - constant PAD_WORD=32'h80000000
  - the H0..H7 / K constants shared with the engine
- Sub-module sha256_last_word_mask: combinational; takes (word, r) and returns the masked word with the 0x80 inserted.

Test Plan:
- "abc", len=3, in word 0x61626300 -> 16 writes: 0x61626380, 13x 0x0, 0x0, 0x00000018; blocks_o=1, done_o pulses once.
- len=0, no input words -> 0x80000000, 14x 0x0, 0x00000000 as LENLO; 16 writes total.
- len=56 (14 words) -> words 0-13 are data, 14=0x80000000, 15=0; second block is 14x 0 then 0, 0x000001C0; blocks_o=2.
- len=64 with fifo_full toggled 50% random -> exactly 32 writes with none while full; word 16=0x80000000, last word=0x00000200; stalled input words are held until accepted.
- rst_i asserted at word 7 of len=100 -> next cycle fifo_wr_en=0 and ready_o=1; a new "abc" job then produces a correct 16-word block.
- With SHA256_PADDER_NONCE_EN: len=3, nonce_ofs_i=3, nonce_i=0xDEADBEEF -> word 3 reads 0xDEADBEEF and all other words match the first test.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, block geometry and the
// round constants also used by the compression engine.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD80,
        ZERO,
        LENHI,
        LENLO
    } state_t;

    localparam int SHA256_BLOCK_WORDS  = 16;
    localparam int SHA256_LEN_WORD_IDX = 14;
    localparam logic [31:0] PAD_WORD   = 32'h8000_0000;

    localparam logic [31:0] SHA256_H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_padder_if.sv
// Word-stream handshake into the padder and write port toward the engine FIFO.
interface sha256_padder_if;
    logic        in_vld_i;
    logic        in_rdy_o;
    logic [31:0] in_dat_i;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_dat;

    modport slave (
        input  in_vld_i, in_dat_i, fifo_full,
        output in_rdy_o, fifo_wr_en, fifo_wr_dat
    );

    modport master (
        output in_vld_i, in_dat_i, fifo_full,
        input  in_rdy_o, fifo_wr_en, fifo_wr_dat
    );
endinterface

// File: rtl/sha256_last_word_mask.sv
// Final partial message word: keep the top r bytes, place 0x80 in byte r,
// zero the remaining lanes (lane 0 is bits [31:24]).
module sha256_last_word_mask (
    input  logic [31:0] word,
    input  logic [1:0]  r,
    output logic [31:0] masked
);
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign masked[31-8*gi -: 8] = (r > 2'(gi))  ? word[31-8*gi -: 8] :
                                          (r == 2'(gi)) ? 8'h80 : 8'h00;
        end
    endgenerate
endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder feeding the engine word FIFO in whole 16-word blocks.
// Optional nonce substitution in the final block: SHA256_PADDER_NONCE_EN.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_len_i,
    output logic             ready_o,
    sha256_padder_if.slave   io,
    output logic [15:0]      blocks_o,
    output logic             done_o
`ifdef SHA256_PADDER_NONCE_EN
    ,
    input  logic [3:0]       nonce_ofs_i,
    input  logic [31:0]      nonce_i
`endif
);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;
    logic [3:0]       wcnt_reg, wcnt_next;
    logic [15:0]      blocks_reg, blocks_next;
    logic             wr_en_reg, done_reg, done_next, produce;
    logic [31:0]      wr_dat_reg, word, masked_word;
    logic [63:0]      bit_len;
    logic             len_word_next;

    assign bit_len       = 64'(len_reg) << 3;
    // After writing at word 13 the next slot is the length field.
    assign len_word_next = (wcnt_reg == 4'(SHA256_LEN_WORD_IDX - 1));

    sha256_last_word_mask u_mask (
        .word   (io.in_dat_i),
        .r      (remaining_reg[1:0]),
        .masked (masked_word)
    );

`ifdef SHA256_PADDER_NONCE_EN
    logic [LEN_W-1:0] blk_idx_reg, blk_idx_next;
    logic [LEN_W:0]   final_blk;
    assign final_blk = ({1'b0, len_reg} + (LEN_W+1)'(8)) >> 6;
`endif

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        remaining_next = remaining_reg;
        wcnt_next      = wcnt_reg;
        blocks_next    = blocks_reg;
        done_next      = 1'b0;
        produce        = 1'b0;
        word           = 32'h0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    len_next       = msg_len_i;
                    remaining_next = msg_len_i;
                    wcnt_next      = 4'd0;
                    blocks_next    = 16'd0;
                    state_next     = (msg_len_i != '0) ? DATA : PAD80;
                end
            end
            DATA: begin
                if (io.in_vld_i && !io.fifo_full) begin
                    produce = 1'b1;
                    if (remaining_reg <= LEN_W'(4)) begin
                        remaining_next = '0;
                        if (remaining_reg[1:0] != 2'd0) begin
                            word       = masked_word;
                            state_next = len_word_next ? LENHI : ZERO;
                        end else begin
                            word       = io.in_dat_i;
                            state_next = PAD80;
                        end
                    end else begin
                        word           = io.in_dat_i;
                        remaining_next = remaining_reg - LEN_W'(4);
                    end
                end
            end
            PAD80: begin
                if (!io.fifo_full) begin
                    produce    = 1'b1;
                    word       = PAD_WORD;
                    state_next = len_word_next ? LENHI : ZERO;
                end
            end
            ZERO: begin
                if (!io.fifo_full) begin
                    produce    = 1'b1;
                    state_next = len_word_next ? LENHI : ZERO;
                end
            end
            LENHI: begin
                if (!io.fifo_full) begin
                    produce    = 1'b1;
                    word       = bit_len[63:32];
                    state_next = LENLO;
                end
            end
            LENLO: begin
                if (!io.fifo_full) begin
                    produce    = 1'b1;
                    word       = bit_len[31:0];
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef SHA256_PADDER_NONCE_EN
        blk_idx_next = (state_reg == IDLE && start_i) ? '0 : blk_idx_reg;
        // Length words always win; nonce offsets 14/15 are not supported.
        if (produce && state_reg != LENHI && state_reg != LENLO &&
            {1'b0, blk_idx_reg} == final_blk && wcnt_reg == nonce_ofs_i)
            word = nonce_i;
        if (produce && wcnt_reg == 4'd15)
            blk_idx_next = blk_idx_reg + LEN_W'(1);
`endif

        if (produce) begin
            wcnt_next = wcnt_reg + 4'd1;
            if (wcnt_reg == 4'd15 && blocks_reg != 16'hFFFF)
                blocks_next = blocks_reg + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            remaining_reg <= '0;
            wcnt_reg      <= 4'd0;
            blocks_reg    <= 16'd0;
            wr_en_reg     <= 1'b0;
            wr_dat_reg    <= 32'h0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            remaining_reg <= remaining_next;
            wcnt_reg      <= wcnt_next;
            blocks_reg    <= blocks_next;
            wr_en_reg     <= produce;
            done_reg      <= done_next;
            if (produce)
                wr_dat_reg <= word;
        end
    end

`ifdef SHA256_PADDER_NONCE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            blk_idx_reg <= '0;
        else
            blk_idx_reg <= blk_idx_next;
    end
`endif

    assign ready_o        = (state_reg == IDLE);
    assign io.in_rdy_o    = (state_reg == DATA) && !io.fifo_full;
    assign io.fifo_wr_en  = wr_en_reg;
    assign io.fifo_wr_dat = wr_dat_reg;
    assign blocks_o       = blocks_reg;
    assign done_o         = done_reg;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder: expected FIFO stream is built from the
// byte-level SHA-256 padding rule and compared word by word.
module tb_sha256_padder;
    localparam int LEN_W = 32;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [LEN_W-1:0] msg_len_i;
    logic             ready_o;
    logic [15:0]      blocks_o;
    logic             done_o;
`ifdef SHA256_PADDER_NONCE_EN
    logic [3:0]       nonce_ofs_i;
    logic [31:0]      nonce_i;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_padder_if io ();

    sha256_padder #(.LEN_W(LEN_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .msg_len_i (msg_len_i),
        .ready_o   (ready_o),
        .io        (io.slave),
        .blocks_o  (blocks_o),
        .done_o    (done_o)
`ifdef SHA256_PADDER_NONCE_EN
        ,
        .nonce_ofs_i (nonce_ofs_i),
        .nonce_i     (nonce_i)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input int len, input int full_pct, input int abort_at,
                           input bit zero_tail, input logic [3:0] ofs,
                           input logic [31:0] nonce, input logic [7:0] fixed[$]);
        logic [7:0]  pb[$];
        logic [31:0] exp_w[$];
        logic [31:0] in_w[$];
        logic [63:0] bits;
        logic [31:0] w;
        int nin, wr_n, done_n, in_idx, cyc, tail;
        bit acc;

        for (int i = 0; i < len; i++)
            pb.push_back((fixed.size() == len) ? fixed[i] : 8'($urandom));
        nin = (len + 3) / 4;
        for (int k = 0; k < nin; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                w = {w[23:0], ((4*k + b) < len) ? pb[4*k + b] : (zero_tail ? 8'h00 : 8'($urandom))};
            in_w.push_back(w);
        end
        // Reference padding: 0x80, zeros to 56 mod 64, then 64-bit big-endian bit count.
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56)
            pb.push_back(8'h00);
        bits = 64'(len) * 64'd8;
        for (int i = 7; i >= 0; i--)
            pb.push_back(bits[8*i +: 8]);
        for (int k = 0; k < pb.size() / 4; k++)
            exp_w.push_back({pb[4*k], pb[4*k+1], pb[4*k+2], pb[4*k+3]});
`ifdef SHA256_PADDER_NONCE_EN
        exp_w[exp_w.size() - 16 + int'(ofs)] = nonce;
        nonce_ofs_i = ofs;
        nonce_i     = nonce;
`endif

        @(negedge clk);
        check("ready_before_start", 64'(ready_o), 64'd1);
        start_i      = 1'b1;
        msg_len_i    = LEN_W'(len);
        io.fifo_full = 1'b0;
        io.in_vld_i  = 1'b0;
        wr_n = 0; done_n = 0; in_idx = 0; cyc = 0; tail = 0; acc = 1'b0;

        while (cyc < 3000 && tail < 4) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (io.fifo_wr_en) begin
                check("no_write_while_full", 64'(io.fifo_full), 64'd0);
                if (wr_n < exp_w.size())
                    check($sformatf("len%0d_word%0d", len, wr_n), 64'(io.fifo_wr_dat), 64'(exp_w[wr_n]));
                else
                    check("extra_write", 64'(wr_n), 64'(exp_w.size()));
                wr_n++;
            end
            if (done_o) done_n++;
            if (done_n > 0) tail++;
            if (acc) in_idx++;
            if (abort_at > 0 && wr_n == abort_at) begin
                rst_i = 1'b1;
                @(negedge clk);
                rst_i = 1'b0;
                io.in_vld_i = 1'b0;
                check("abort_wr_en", 64'(io.fifo_wr_en), 64'd0);
                check("abort_ready", 64'(ready_o), 64'd1);
                check("abort_in_rdy", 64'(io.in_rdy_o), 64'd0);
                check("abort_blocks", 64'(blocks_o), 64'd0);
                $display("job len=%0d aborted after %0d writes", len, wr_n);
                return;
            end
            // Fullness sampled at the write above is the value the DUT decided on.
            io.fifo_full = ($urandom_range(99) < full_pct);
            if (!(io.in_vld_i && !acc)) begin
                io.in_vld_i = ($urandom_range(3) != 0);
                io.in_dat_i = (in_idx < nin) ? in_w[in_idx] : $urandom;
            end
            #1;
            acc = io.in_vld_i && io.in_rdy_o;
        end

        io.in_vld_i  = 1'b0;
        io.fifo_full = 1'b0;
        check("done_count", 64'(done_n), 64'd1);
        check("write_count", 64'(wr_n), 64'(exp_w.size()));
        check("blocks", 64'(blocks_o), 64'(exp_w.size() / 16));
        check("ready_after", 64'(ready_o), 64'd1);
        $display("job len=%0d writes=%0d blocks=%0d ofs=%0d nonce=%h cycles=%0d",
                 len, wr_n, blocks_o, ofs, nonce, cyc);
    endtask

    initial begin
        logic [7:0] abc[$];
        logic [7:0] none[$];
        abc = '{8'h61, 8'h62, 8'h63};

        rst_i = 1'b1; start_i = 1'b0; msg_len_i = '0;
        io.in_vld_i = 1'b0; io.in_dat_i = 32'h0; io.fifo_full = 1'b0;
`ifdef SHA256_PADDER_NONCE_EN
        nonce_ofs_i = 4'd0; nonce_i = 32'h0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_in_rdy", 64'(io.in_rdy_o), 64'd0);
        check("rst_wr_en", 64'(io.fifo_wr_en), 64'd0);
        check("rst_wr_dat", 64'(io.fifo_wr_dat), 64'd0);
        check("rst_blocks", 64'(blocks_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b0;

        run_job(3, 0, 0, 1'b1, 4'd3, 32'hDEADBEEF, abc);
        run_job(0, 20, 0, 1'b0, 4'd0, $urandom, none);
        run_job(56, 0, 0, 1'b0, 4'd13, $urandom, none);
        run_job(55, 30, 0, 1'b0, 4'd7, $urandom, none);
        run_job(64, 50, 0, 1'b0, 4'(($urandom_range(13))), $urandom, none);
        run_job(100, 20, 7, 1'b0, 4'd0, $urandom, none);
        run_job(3, 0, 0, 1'b1, 4'd3, 32'hDEADBEEF, abc);
        for (int j = 0; j < 8; j++)
            run_job(int'($urandom_range(200)), 30, 0, 1'b0, 4'($urandom_range(13)), $urandom, none);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
